// File: rtl/niosii_debug_pkg.sv
// rtl/niosii_debug_pkg.sv - shared IR codes, default widths and clog2 helper for the debug command path
package niosii_debug_pkg;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACECTRL = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACEMEM  = 2'd3;

    localparam int DEF_IR_WIDTH    = 2;
    localparam int DEF_DR_WIDTH    = 38;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/niosii_debug_cmd_sync_if.sv
// rtl/niosii_debug_cmd_sync_if.sv - command stream from the sysclk receiver to the CPU debug logic
interface niosii_debug_cmd_sync_if
    import niosii_debug_pkg::*;
#(
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int DR_WIDTH = DEF_DR_WIDTH
);
    localparam int NA = 1 << IR_WIDTH;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [DR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] jir;
    logic [NA-1:0]       take_action;

    modport master (output cmd_valid, jdo, jir, take_action, input cmd_ready);
    modport slave  (input cmd_valid, jdo, jir, take_action, output cmd_ready);

endinterface

// File: rtl/niosii_debug_sync_edge.sv
// rtl/niosii_debug_sync_edge.sv - synchronises vs_udr and emits one armed rising-edge pulse
module niosii_debug_sync_edge
    import niosii_debug_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   udr_d_q, udr_d_d;
    logic                   armed_q, armed_d;
    logic                   udr_s;
    logic                   udr_s_real;

    // fill_q marks when udr_s holds a genuine sample rather than reset zeros,
    // so a strobe already high at reset release cannot arm the detector.
    always_comb begin
        udr_s      = sync_q[SYNC_STAGES-1];
        udr_s_real = fill_q[SYNC_STAGES-1];
        sync_d     = {sync_q[SYNC_STAGES-2:0], din};
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        udr_d_d    = udr_s;
        armed_d    = armed_q | (udr_s_real & ~udr_s);
        pulse      = udr_s & ~udr_d_q & armed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            udr_d_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            udr_d_q <= udr_d_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/niosii_debug_cmd_sync.sv
// rtl/niosii_debug_cmd_sync.sv - sysclk JTAG debug command receiver with FIFO, back-pressure and overflow
module niosii_debug_cmd_sync
    import niosii_debug_pkg::*;
#(
    parameter int IR_WIDTH    = DEF_IR_WIDTH,
    parameter int DR_WIDTH    = DEF_DR_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        vs_udr,
    input  logic [IR_WIDTH-1:0]         ir_in,
    input  logic [DR_WIDTH-1:0]         sr,
    input  logic                        clr_overflow,
    niosii_debug_cmd_sync_if.master     cmd,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                        overflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = IR_WIDTH + DR_WIDTH;
    localparam int NA = 1 << IR_WIDTH;

    typedef logic [EW-1:0] entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic          push_ev;
    logic          empty, full, pop, push_ok, drop;
    entry_t        head;
    logic [NA-1:0] action;

    niosii_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vs_udr),
        .pulse   (push_ev)
    );

    // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
    always_comb begin
        empty      = (wptr_q == rptr_q);
        full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop        = !empty && cmd.cmd_ready;
        push_ok    = push_ev && (!full || pop);
        drop       = push_ev && full && !pop;
        wptr_d     = wptr_q + PW'(push_ok);
        rptr_d     = rptr_q + PW'(pop);
        level_d    = wptr_d - rptr_d;
        overflow_d = drop || (overflow_q && !clr_overflow);
        mem_d      = mem_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = {ir_in, sr};
        end
        head = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_comb begin
        action = '0;
        for (int i = 0; i < NA; i++) begin
            action[i] = pop && (head[EW-1:DR_WIDTH] == IR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately unreset; the read side is gated while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd.cmd_valid   = !empty;
    assign cmd.jdo         = head[DR_WIDTH-1:0];
    assign cmd.jir         = head[EW-1:DR_WIDTH];
    assign cmd.take_action = action;
    assign fifo_level      = level_q;
    assign overflow        = overflow_q;

endmodule
